widget2_deframer: RTL

//   Receive-side stage directly downstream of widget2_rtl: consumes its 1-bit

---
 rtl/widget2_deframer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/widget2_deframer.sv
// rtl/widget2_deframer.sv - serial frame receiver with checked-word output FIFO
module widget2_deframer #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              serial_in_i,
  output logic [DATA_W-1:0]                 out_data_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              parity_err_o,
  output logic                              frame_err_o,
  output logic                              overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0]  shift_q;
  logic               par_bad_q;
  logic               parity_err_q;
  logic               frame_err_q;
  logic               overflow_q;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   count_q, count_d;
  logic               overflow_d;

  logic               push_w;
  logic               pop_w;
  logic               full_w;
  logic               wr_en_w;

  // A good word is offered to the FIFO on the stop-bit edge itself.
  assign push_w  = (state_q == ST_STOP) && serial_in_i && !par_bad_q;
  assign pop_w   = (count_q != '0) && out_ready_i;
  assign full_w  = (count_q == LVL_W'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign wr_en_w = push_w && (!full_w || pop_w);

  // Frame recovery: start/data/parity/stop sequencing, error pulses registered for one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!serial_in_i) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
            par_bad_q <= 1'b0;
          end
        end
        ST_DATA: begin
          shift_q   <= {serial_in_i, shift_q[DATA_W-1:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          par_bad_q <= (^shift_q) ^ serial_in_i;
          state_q   <= ST_STOP;
        end
        ST_STOP: begin
          if (serial_in_i) begin
            state_q      <= ST_IDLE;
            parity_err_q <= par_bad_q;
          end else begin
            // Framing error takes precedence; the parity result is discarded.
            state_q     <= ST_BREAK;
            frame_err_q <= 1'b1;
          end
        end
        ST_BREAK: begin
          if (serial_in_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIFO next-state: pointer advance, occupancy and overflow detection.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = push_w && full_w && !pop_w;
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en_w) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({wr_en_w, pop_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_w) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data_o   = mem_q[rd_ptr_q];
  assign out_valid_o  = (count_q != '0);
  assign level_o      = count_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;

endmodule
